// File: rtl/fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_ctrl                                                      |
// | Purpose  : Fetch sequencer. Owns the program counter, drives the           |
// |            instruction-memory req/ack handshake, merges sequential         |
// |            advance, jump redirects and decode back-pressure into a single  |
// |            fetch stream, and presents a buffered inst/PC pair to decode.   |
// | Ports    : clk, rst          - clock, synchronous active-high reset        |
// |            jump, jump_addr   - redirect request/target from execute        |
// |            stall             - decode cannot accept inst this cycle        |
// |            imem_req/addr     - fetch request and address to memory         |
// |            imem_ack/rdata    - memory response (same-cycle ack allowed)    |
// |            inst_valid/inst/inst_pc - buffered instruction to decode        |
// |            next_pc           - next sequential fetch address (trace)       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump,
  input  logic [31:0] jump_addr,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] next_pc
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] next_pc_q, next_pc_d;
  logic [31:0] target_q, target_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_data_q, skid_data_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic        consume;
  logic        out_free;
  logic [31:0] jump_tgt;
  logic [31:0] addr_inc;

  assign consume  = out_valid_q && !stall;
  assign out_free = !out_valid_q || consume;
  assign jump_tgt = jump_addr & 32'hFFFF_FFFC;
  assign addr_inc = addr_q + 32'd4;

  assign imem_req   = (state_q == ST_REQ) || (state_q == ST_DRAIN);
  assign imem_addr  = addr_q;
  assign inst_valid = out_valid_q;
  assign inst       = out_valid_q ? out_data_q : NOP_INST;
  assign inst_pc    = out_pc_q;
  assign next_pc    = next_pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BOOT;
      addr_q       <= RESET_PC;
      next_pc_q    <= RESET_PC;
      target_q     <= RESET_PC;
      out_valid_q  <= 1'b0;
      out_data_q   <= NOP_INST;
      out_pc_q     <= RESET_PC;
      skid_valid_q <= 1'b0;
      skid_data_q  <= 32'd0;
      skid_pc_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      next_pc_q    <= next_pc_d;
      target_q     <= target_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    next_pc_d    = next_pc_q;
    target_d     = target_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_pc_d    = skid_pc_q;

    if (jump) begin
      // Redirect flushes both buffered entries regardless of stall.
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      target_d     = jump_tgt;
      next_pc_d    = jump_tgt;
      case (state_q)
        // An un-acked request must complete before the target can be issued.
        ST_REQ, ST_DRAIN: begin
          if (imem_ack) begin
            state_d = ST_REQ;
            addr_d  = jump_tgt;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: begin
          state_d = ST_REQ;
          addr_d  = jump_tgt;
        end
      endcase
    end else begin
      if (consume) begin
        if (skid_valid_q) begin
          out_data_d   = skid_data_q;
          out_pc_d     = skid_pc_q;
          skid_valid_d = 1'b0;
        end else begin
          out_valid_d = 1'b0;
        end
      end

      case (state_q)
        ST_BOOT: begin
          state_d   = ST_REQ;
          addr_d    = RESET_PC;
          next_pc_d = RESET_PC;
        end
        ST_REQ: begin
          if (imem_ack) begin
            next_pc_d = addr_inc;
            // Requests are only in flight with an empty skid, so the ack
            // lands either in the output register or in the skid.
            if (out_free) begin
              out_data_d  = imem_rdata;
              out_pc_d    = addr_q;
              out_valid_d = 1'b1;
              addr_d      = addr_inc;
            end else begin
              skid_data_d  = imem_rdata;
              skid_pc_d    = addr_q;
              skid_valid_d = 1'b1;
              state_d      = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!skid_valid_d) begin
            state_d = ST_REQ;
            addr_d  = next_pc_q;
          end
        end
        ST_DRAIN: begin
          // Response to the pre-redirect address is dropped.
          if (imem_ack) begin
            state_d = ST_REQ;
            addr_d  = target_q;
          end
        end
        default: state_d = ST_BOOT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fetch_ctrl                                                   |
// | Purpose  : Directed, self-checking bench for fetch_ctrl with a scoreboard  |
// |            of acked instructions compared at consumption by decode.        |
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_fetch_ctrl;

  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] C_NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        jump;
  logic [31:0] jump_addr;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] next_pc;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] sb_q[$];
  logic        drain_pending = 1'b0;

  fetch_ctrl #(
    .RESET_PC (C_RESET_PC),
    .NOP_INST (C_NOP)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .jump       (jump),
    .jump_addr  (jump_addr),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .next_pc    (next_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req"},     32'(imem_req),   32'd0);
    chk({tag, "_addr"},    imem_addr,       C_RESET_PC);
    chk({tag, "_valid"},   32'(inst_valid), 32'd0);
    chk({tag, "_inst"},    inst,            C_NOP);
    chk({tag, "_inst_pc"}, inst_pc,         C_RESET_PC);
    chk({tag, "_next_pc"}, next_pc,         C_RESET_PC);
  endtask

  // One clock cycle: drive inputs just after posedge, observe at negedge,
  // update the scoreboard from what memory and decode see, advance.
  task automatic cyc(input logic ack, input logic st, input logic jmp, input logic [31:0] ja);
    logic [63:0] e;
    imem_ack   = ack;
    stall      = st;
    jump       = jmp;
    jump_addr  = ja;
    imem_rdata = ~imem_addr;
    @(negedge clk);
    if (rst) begin
      sb_q.delete();
      drain_pending = 1'b0;
    end else if (jmp) begin
      sb_q.delete();
      drain_pending = imem_req && !ack;
    end else begin
      if (inst_valid && !st) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_inst_pc", inst_pc, 32'hDEAD_BEEF);
        end else begin
          e = sb_q.pop_front();
          chk("sb_inst_pc", inst_pc, e[63:32]);
          chk("sb_inst",    inst,    e[31:0]);
        end
      end
      if (imem_req && ack) begin
        if (drain_pending) drain_pending = 1'b0;
        else sb_q.push_back({imem_addr, ~imem_addr});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    imem_ack   = 1'b0;
    stall      = 1'b0;
    jump       = 1'b0;
    jump_addr  = 32'd0;
    imem_rdata = 32'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_reset("rst");

    // Sequential fetch, single-cycle ack
    rst = 1'b0;
    chk("boot_req", 32'(imem_req), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("seq_req",  32'(imem_req), 32'd1);
      chk("seq_addr", imem_addr, 32'(4 * k));
      if (k > 0) begin
        chk("seq_valid", 32'(inst_valid), 32'd1);
        chk("seq_pc",    inst_pc, 32'(4 * (k - 1)));
      end
      cyc(1'b1, 1'b0, 1'b0, 32'd0);
    end
    chk("seq_addr4", imem_addr, 32'h10);

    // Stall with acks continuing: skid fills, request drops
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    for (int k = 0; k < 2; k++) begin
      chk("wait_req",   32'(imem_req), 32'd0);
      chk("stall_pc",   inst_pc, 32'hC);
      chk("stall_inst", inst, ~32'hC);
      cyc(1'b1, 1'b1, 1'b0, 32'd0);
    end
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk("resume_req",  32'(imem_req), 32'd1);
    chk("resume_addr", imem_addr, 32'h14);
    chk("resume_pc",   inst_pc, 32'h10);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);

    // Jump with no ack: drain old request, then fetch target
    chk("pre_jump_addr", imem_addr, 32'h1C);
    cyc(1'b0, 1'b0, 1'b1, 32'h100);
    chk("drain_valid", 32'(inst_valid), 32'd0);
    chk("drain_inst",  inst, C_NOP);
    chk("drain_req",   32'(imem_req), 32'd1);
    chk("drain_addr",  imem_addr, 32'h1C);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk("drain_addr2", imem_addr, 32'h1C);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    chk("tgt_req",   32'(imem_req), 32'd1);
    chk("tgt_addr",  imem_addr, 32'h100);
    chk("tgt_valid", 32'(inst_valid), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    chk("tgt_out_valid", 32'(inst_valid), 32'd1);
    chk("tgt_out_pc",    inst_pc, 32'h100);

    // Jump coincident with ack, unaligned target
    cyc(1'b1, 1'b0, 1'b1, 32'h203);
    chk("jack_valid", 32'(inst_valid), 32'd0);
    chk("jack_addr",  imem_addr, 32'h200);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    chk("jack_out_pc", inst_pc, 32'h200);
    chk("jack_inst",   inst, ~32'h200);

    // Jump while stalled with full skid
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    chk("full_req", 32'(imem_req), 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 32'h300);
    chk("flush_valid", 32'(inst_valid), 32'd0);
    chk("flush_req",   32'(imem_req), 32'd1);
    chk("flush_addr",  imem_addr, 32'h300);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    chk("flush_out_pc", inst_pc, 32'h300);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);

    // Address wrap
    cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    chk("wrap_drain_addr", imem_addr, 32'h304);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    chk("wrap_next_addr", imem_addr, 32'h0);
    chk("wrap_next_pc",   next_pc, 32'h0);
    chk("wrap_inst_pc",   inst_pc, 32'hFFFF_FFFC);
    chk("wrap_valid",     32'(inst_valid), 32'd1);

    // Mid-request reset and stray acks
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    check_reset("midrst");
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    check_reset("stray_rst");
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    chk("post_rst_req",   32'(imem_req), 32'd1);
    chk("post_rst_addr",  imem_addr, C_RESET_PC);
    chk("post_rst_valid", 32'(inst_valid), 32'd0);
    chk("post_rst_inst",  inst, C_NOP);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    chk("post_rst_out_valid", 32'(inst_valid), 32'd1);
    chk("post_rst_out_pc",    inst_pc, C_RESET_PC);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer that owns the program counter and drives the instruction-memory request/acknowledge handshake. Merges sequential advance, jump redirects and decode back-pressure into a single fetch stream. Presents a buffered instruction/PC pair to decode. Sits between the instruction memory and the decode stage; jump and jump_addr come from the execute stage.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)
- NOP_INST, 32'h0000_0013, value driven on inst when no valid instruction is held
- clk  input  1  clock; all state changes on its rising edge
- rst  input  1  reset, synchronous, active-high
- jump  input  1  redirect request from execute
- jump_addr  input  32  redirect target; bits [1:0] ignored and forced to 0
- stall  input  1  decode cannot accept inst this cycle
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  32  fetch address; stable while imem_req=1 and no ack
- imem_ack  input  1  memory returns imem_rdata this cycle (same-cycle ack allowed)
- imem_rdata  input  32  fetched instruction word
- inst_valid  output  1  inst and inst_pc hold a live instruction
- inst  output  32  instruction to decode
- inst_pc  output  32  address of inst
- next_pc  output  32  address of the next sequential fetch, for debug/trace

## Operation
- Storage:
  - Output register (inst, inst_pc, inst_valid).
  - One-entry skid register (data, pc, valid).
- Consumption: the output entry is consumed when inst_valid=1 and stall=0. On consumption the skid entry, if valid, moves to the output register.
- Ack while output register is empty or being consumed: data goes to the output register. Otherwise it goes to the skid entry.
- A new request is issued only when the skid entry is empty. At most one request is outstanding.
- FSM states:
  - BOOT: entered on rst. Next cycle goes to REQ with imem_addr=RESET_PC.
  - REQ: imem_req=1. On ack with no jump:
    - next_pc <= imem_addr+4.
    - If the skid will be empty next cycle, stay in REQ at the new address.
    - Otherwise go to WAIT.
  - WAIT: imem_req=0. Returns to REQ at next_pc once the skid drains.
  - DRAIN: imem_req=1 at the old address until ack. The ack data is discarded. Then goes to REQ at the captured redirect target.
- Jump has the highest priority and overrides stall. In the cycle after jump=1:
  - The output and skid entries are cleared and inst_valid=0.
  - The target is captured.
  - Next state depends on the state when jump was sampled:
    - REQ with no ack: DRAIN.
    - REQ with ack: REQ at the target, and the acked data is discarded.
    - WAIT or BOOT: REQ at the target.
- A jump during DRAIN overwrites the captured target.
- Address arithmetic is modulo 2^32: next_pc wraps from 32'hFFFF_FFFC to 0.
- When inst_valid=0, inst shows NOP_INST.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC.
  - inst_valid=0, inst=NOP_INST, inst_pc=RESET_PC.
  - next_pc=RESET_PC, skid empty, state BOOT.
- First imem_req=1 occurs in the 1st cycle after rst deasserts.
- Latency: ack in cycle N gives inst_valid=1 in cycle N+1, provided the output entry is free.
- Throughput with a single-cycle ack and no stall: one instruction per cycle.
- Jump sampled in cycle N: inst_valid=0 in N+1.
  - Earliest imem_req at the target is in N+1 (no outstanding request).
  - Otherwise it is the cycle after the drain ack.
- Stall holds inst, inst_pc and inst_valid unchanged, except when jump clears them.
- rst asserted mid-operation takes effect at the next edge. An outstanding request is abandoned, and a later stray imem_ack is ignored because imem_req=0.
- imem_ack while imem_req=0 is ignored in every state.

## Test plan
- Reset then single-cycle ack, no stall:
  - imem_addr steps 0,4,8,C.
  - inst_pc follows one cycle behind, inst equals imem_rdata.
  - inst_valid is continuous from cycle 2.
- Stall for 3 cycles while acks continue:
  - The output holds the same inst.
  - The skid fills and imem_req drops (WAIT).
  - After stall falls, instructions appear in order with no loss or duplication.
- Jump to 0x100 in a REQ cycle with no ack, ack after 2 cycles:
  - DRAIN data is discarded.
  - The next imem_addr is 0x100.
  - inst_valid=0 until 0x100 returns.
- Jump to 0x203 in the same cycle as an ack:
  - The acked word is discarded.
  - The next request is at 0x200.
  - The first inst_pc after the jump is 0x200.
- Jump while stall=1 with a full skid: both entries are flushed, inst_valid=0 next cycle, fetch restarts at the target.
- Wrap and mid-operation reset:
  - Start fetching at 0xFFFF_FFFC and confirm the next address is 0.
  - Assert rst mid-request and confirm all reset values, and that a stray ack is ignored.
